// File: rtl/addition_stage2_align.sv
// FP adder stage 2: aligns the smaller operand's mantissa by |exp_diff| with sticky collection.
// Define ALIGN_BARREL_SHIFT_EN to replace the 1-bit/cycle shifter with a single-cycle barrel shifter.
module addition_stage2_align #(
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  start_in,
   input  logic [EXPO_WIDTH:0]   exp_diff_in,
   input  logic [MENT_WIDTH-1:0] smaller_operand_in,
   input  logic                  hidden_bit_in,
   input  logic                  ready_in,
   output logic                  ready_out,
   output logic                  valid_out,
   output logic [MENT_WIDTH+3:0] aligned_mantissa_out
);

   localparam int AW = MENT_WIDTH + 4;
   localparam logic [EXPO_WIDTH:0]   SAT_LIMIT = (EXPO_WIDTH+1)'(AW);
   localparam logic [EXPO_WIDTH-1:0] CNT_SAT   = EXPO_WIDTH'(AW);
   localparam logic [EXPO_WIDTH-1:0] CNT_ZERO  = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [AW-1:0]       out_reg, out_next;
   logic [EXPO_WIDTH:0] mag;
   logic [EXPO_WIDTH-1:0] count_load;
   logic [AW-1:0]       load_vec;

   // -256 cannot occur, so the low EXPO_WIDTH bits of mag are exact whenever mag is not saturated
   assign mag        = exp_diff_in[EXPO_WIDTH] ? -exp_diff_in : exp_diff_in;
   assign count_load = (mag > SAT_LIMIT) ? CNT_SAT : mag[EXPO_WIDTH-1:0];
   assign load_vec   = {hidden_bit_in, smaller_operand_in, 3'b000};

   assign ready_out            = (state_reg == IDLE);
   assign valid_out            = (state_reg == DONE);
   assign aligned_mantissa_out = out_reg;

`ifdef ALIGN_BARREL_SHIFT_EN

   logic [AW-1:0] shifted_vec;
   logic [AW-1:0] sticky_mask;
   logic [AW-1:0] barrel_result;

   // Bits [count:0] of the pre-shift vector all collapse into the sticky position
   for (genvar gi = 0; gi < AW; gi++) begin : g_sticky_mask
      assign sticky_mask[gi] = (EXPO_WIDTH'(gi) <= count_load);
   end

   assign shifted_vec   = load_vec >> count_load;
   assign barrel_result = {shifted_vec[AW-1:1], |(load_vec & sticky_mask)};

   always_comb begin
      state_next = state_reg;
      out_next   = out_reg;
      case (state_reg)
         IDLE: begin
            if (start_in) begin
               out_next   = barrel_result;
               state_next = DONE;
            end
         end
         DONE: begin
            if (ready_in) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg <= IDLE;
         out_reg   <= '0;
      end else begin
         state_reg <= state_next;
         out_reg   <= out_next;
      end
   end

`else

   localparam logic [EXPO_WIDTH-1:0] CNT_ONE = EXPO_WIDTH'(1);

   logic [EXPO_WIDTH-1:0] count_reg, count_next;
   logic [AW-1:0]         shift_reg, shift_next;
   logic [AW-1:0]         shift_step;

   // One position per cycle; bit 0 keeps the OR of everything that has fallen off the end
   assign shift_step = {1'b0, shift_reg[AW-1:2], shift_reg[1] | shift_reg[0]};

   always_comb begin
      state_next = state_reg;
      out_next   = out_reg;
      count_next = count_reg;
      shift_next = shift_reg;
      case (state_reg)
         IDLE: begin
            if (start_in) begin
               shift_next = load_vec;
               count_next = count_load;
               if (count_load == CNT_ZERO) begin
                  out_next   = load_vec;
                  state_next = DONE;
               end else begin
                  state_next = SHIFT;
               end
            end
         end
         SHIFT: begin
            shift_next = shift_step;
            count_next = count_reg - CNT_ONE;
            if (count_reg == CNT_ONE) begin
               out_next   = shift_step;
               state_next = DONE;
            end
         end
         DONE: begin
            if (ready_in) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg <= IDLE;
         out_reg   <= '0;
         count_reg <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         out_reg   <= out_next;
         count_reg <= count_next;
         shift_reg <= shift_next;
      end
   end

`endif

endmodule

// File: tb/tb_addition_stage2_align.sv
// Randomized and directed bench for addition_stage2_align against an arithmetic reference model.
module tb_addition_stage2_align;

   localparam int MW = 23;
   localparam int EW = 8;
   localparam int AW = MW + 4;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          start_in = 1'b0;
   logic [EW:0]   exp_diff_in = '0;
   logic [MW-1:0] smaller_operand_in = '0;
   logic          hidden_bit_in = 1'b0;
   logic          ready_in = 1'b0;
   logic          ready_out;
   logic          valid_out;
   logic [AW-1:0] aligned_mantissa_out;

   int pass_count = 0;
   int check_count = 0;

   addition_stage2_align #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW)) dut (
      .clk_in              (clk_in),
      .rst_n_in            (rst_n_in),
      .start_in            (start_in),
      .exp_diff_in         (exp_diff_in),
      .smaller_operand_in  (smaller_operand_in),
      .hidden_bit_in       (hidden_bit_in),
      .ready_in            (ready_in),
      .ready_out           (ready_out),
      .valid_out           (valid_out),
      .aligned_mantissa_out(aligned_mantissa_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_count++;
      if (got === exp) begin
         pass_count++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ref_count(input logic [EW:0] d);
      int v;
      int m;
      v = d[EW] ? (int'(d) - (1 << (EW + 1))) : int'(d);
      m = (v < 0) ? -v : v;
      return (m > AW) ? AW : m;
   endfunction

   function automatic logic [AW-1:0] ref_align(input logic [EW:0] d, input logic [MW-1:0] m, input logic h);
      longint vec;
      longint res;
      longint mask;
      int c;
      c    = ref_count(d);
      vec  = longint'({h, m, 3'b000});
      res  = vec >> c;
      mask = (longint'(1) << (c + 1)) - 1;
      if ((vec & mask) != 0) res = res | 1;
      else                   res = res & ~longint'(1);
      return res[AW-1:0];
   endfunction

   task automatic run_op(input logic [EW:0] d, input logic [MW-1:0] m, input logic h,
                         input logic [AW-1:0] exp_val, input int hold, input bit pulse);
      int lat;
      int exp_lat;
      logic [AW-1:0] held;
`ifdef ALIGN_BARREL_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = 1 + ref_count(d);
`endif
      check_val("ready_idle", ready_out, 1);
      exp_diff_in        = d;
      smaller_operand_in = m;
      hidden_bit_in      = h;
      start_in           = 1'b1;
      @(negedge clk_in);
      start_in           = 1'b0;
      exp_diff_in        = (EW+1)'($urandom);
      smaller_operand_in = MW'($urandom);
      hidden_bit_in      = 1'($urandom);
      lat = 1;
      while (!valid_out && lat < 200) begin
         start_in = pulse && (lat == 2);
         @(negedge clk_in);
         start_in = 1'b0;
         lat++;
      end
      check_val("latency", lat, exp_lat);
      check_val("data", aligned_mantissa_out, exp_val);
      check_val("ready_busy", ready_out, 0);
      held = aligned_mantissa_out;
      repeat (hold) begin
         start_in = pulse;
         @(negedge clk_in);
         start_in = 1'b0;
         check_val("hold_valid", valid_out, 1);
         check_val("hold_data", aligned_mantissa_out, held);
      end
      ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      check_val("valid_drop", valid_out, 0);
      check_val("ready_back", ready_out, 1);
      check_val("idle_hold", aligned_mantissa_out, held);
      $display("op diff=%h mant=%h hidden=%0d -> %h latency %0d", d, m, h, held, lat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [EW:0]   rd;
      logic [MW-1:0] rm;
      logic          rh;
      int            dv;

      repeat (2) @(negedge clk_in);
      check_val("rst_ready", ready_out, 1);
      check_val("rst_valid", valid_out, 0);
      check_val("rst_data", aligned_mantissa_out, 0);
      rst_n_in = 1'b1;
      @(negedge clk_in);

      run_op(9'h002, 23'h400000, 1'b1, 27'h1800000, 0, 1'b0);
      run_op(9'h1FE, 23'h400000, 1'b1, 27'h1800000, 0, 1'b0);
      run_op(9'h000, 23'h400000, 1'b1, 27'h6000000, 0, 1'b0);
      run_op(9'h0FF, 23'h000001, 1'b1, 27'h0000001, 0, 1'b0);
      run_op(9'h0FF, 23'h000000, 1'b0, 27'h0000000, 0, 1'b0);
      run_op(9'h004, 23'h7FFFFF, 1'b1, 27'h07FFFFF, 5, 1'b1);

      // Abort an operation part-way through
      check_val("abort_ready", ready_out, 1);
      exp_diff_in        = 9'h010;
      smaller_operand_in = 23'h123456;
      hidden_bit_in      = 1'b1;
      start_in           = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      check_val("abort_valid", valid_out, 0);
      check_val("abort_data", aligned_mantissa_out, 0);
      check_val("abort_ready_now", ready_out, 1);
      $display("reset applied mid-operation");
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      run_op(9'h010, 23'h000003, 1'b1, 27'h0000401, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) dv = int'($urandom_range(0, 60)) - 30;
         else                           dv = int'($urandom_range(0, 510)) - 255;
         rd = (EW+1)'(dv);
         rm = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
         rh = 1'($urandom);
         run_op(rd, rm, rh, ref_align(rd, rm, rh), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
